// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial CPU data path (serializer and deserializer sides).
package bs_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bs_state_e;

  localparam int unsigned BS_WIDTH = 8;

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable up-counter for serial frames; o_term marks the increment that reaches WIDTH,
// on which the count folds back to zero so it never holds a value above WIDTH-1.
module serial_bit_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_term
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign o_term  = i_inc && (count_q == CNT_W'(WIDTH - 1));
  assign o_count = count_q;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_inc) begin
      count_d = o_term ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_result_port.sv
// Bit-serial result deserializer: rebuilds an LSB-first stream into a word and holds it
// for the display side under a valid/ack handshake, flagging dropped words as overrun.
module serial_result_port
  import bs_pkg::*;
#(
  parameter int unsigned WIDTH = BS_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_frame_start,
  input  logic             i_bit,
  input  logic             i_bit_valid,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_word,
  output logic             o_word_valid,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_bit_count,
  output logic             o_overrun
);

  bs_state_e        state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] assembled;
  logic             cnt_inc;
  logic             cnt_term;

  // New bits enter at the MSB so the first bit of the frame lands in bit 0 after WIDTH shifts.
  assign assembled = {i_bit, sr_q[WIDTH-1:1]};
  assign cnt_inc   = (state_q == SHIFT) && i_bit_valid && !i_frame_start;

  serial_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (i_frame_start),
    .i_load_val (CNT_W'(i_bit_valid)),
    .i_inc      (cnt_inc),
    .o_count    (o_bit_count),
    .o_term     (cnt_term)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (i_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (i_frame_start) begin
      state_d = SHIFT;
      sr_d    = {i_bit & i_bit_valid, {(WIDTH-1){1'b0}}};
    end else if (cnt_inc) begin
      sr_d = assembled;
      if (cnt_term) begin
        state_d = IDLE;
        // A same-cycle ack frees the holding register, so the new word is not an overrun.
        if (!valid_q || i_ack) begin
          word_d  = assembled;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q == SHIFT);

endmodule

// File: doc/serial_result_port.md
# serial_result_port

Bit-serial result deserializer for the bit-serial CPU. It is the receiving end of the CPU's serial data path: it captures the LSB-first bit stream shifted out of the register file and rebuilds a parallel word. It then holds that word for the LED/display side under a valid/ack handshake. It mirrors the switch-side serializer, which turns parallel switch data into one bit per cycle.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal values 2..16.
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_frame_start  input  1  single-cycle pulse that opens a new frame.
- i_bit  input  1  serial data bit, LSB first.
- i_bit_valid  input  1  i_bit is sampled on this cycle.
- i_ack  input  1  consumer has taken o_word.
- o_word  output  WIDTH  last completed word; reset value 0.
- o_word_valid  output  1  o_word holds an unacknowledged word; reset value 0.
- o_busy  output  1  a frame is in progress; reset value 0.
- o_bit_count  output  CNT_W  bits captured in the current frame; reset value 0.
- o_overrun  output  1  sticky flag: a completed word was dropped; reset value 0.

## Operation
- FSM states are IDLE and SHIFT. Reset puts the FSM in IDLE, clears the shift register, counter, o_word, o_word_valid and o_overrun.
- IDLE:
  - i_frame_start moves the FSM to SHIFT and clears the counter and shift register.
  - If i_bit_valid is high in the same cycle, that bit is captured as bit 0 and the counter becomes 1.
  - i_bit_valid without i_frame_start is ignored.
- SHIFT:
  - Each cycle with i_bit_valid shifts i_bit into the MSB end of the shift register and shifts the register right. After WIDTH bits, bit 0 is the first bit received.
  - The counter increments on each captured bit.
  - Cycles without i_bit_valid are stalls; the state holds.
- Completion: when the WIDTH-th bit is captured, the frame is complete and the FSM returns to IDLE.
  - If o_word_valid is 0, or i_ack is high in the same cycle: o_word loads the assembled word and o_word_valid is set.
  - Otherwise: the new word is dropped, o_word is unchanged and o_overrun is set.
- i_frame_start in SHIFT aborts the current frame. The partial bits are discarded, the counter restarts, and o_word and o_overrun are unaffected.
- i_ack with o_word_valid high clears o_word_valid and o_overrun. i_ack while o_word_valid is low has no effect.
- o_busy = (state == SHIFT).

## Timing
- Latency: o_word and o_word_valid update on the same edge that captures the last bit. They are visible in the cycle after that bit was presented.
- o_bit_count is registered and reads 0 for the whole cycle in which the frame completes.
- Minimum frame length is WIDTH cycles. Back-to-back frames need one i_frame_start pulse each; the start may coincide with the first bit.
- Simultaneous completion and i_ack: the new word is loaded, o_word_valid stays 1, and there is no overrun.
- Asynchronous i_rst mid-frame: all outputs go to reset values immediately. The partial frame is lost.
- Counter width rule: the counter never exceeds WIDTH. There is no wrap-around in the valid range.

## Structure
- Shared package bs_pkg holds:
  - the state enum: IDLE, SHIFT
  - the default word width constant: 8
- Sub-module serial_bit_counter: loadable/clearable up-counter with a terminal flag at WIDTH. It is reused for the serializer side.
- Top of this block: FSM, shift register, holding register and overrun logic.

## Test plan
- Reset, then a frame with bits 1,0,1,0,0,1,1,0 (LSB first) → o_word = 8'h65, o_word_valid = 1 one cycle after the 8th bit, o_busy drops to 0.
- Same frame with i_bit_valid low for 3 cycles after bit 4 → o_word = 8'h65, and o_bit_count holds at 4 during the stall.
- Two frames (8'hA5, then 8'h3C) with no ack → o_word stays 8'hA5 and o_overrun = 1. Then i_ack → o_word_valid = 0 and o_overrun = 0.
- Second frame completes on the same cycle as i_ack → o_word = 8'h3C, o_word_valid stays 1, o_overrun = 0.
- i_frame_start after 5 bits of 8'hFF, then a full 8'h81 frame → o_word = 8'h81, with no intermediate valid.
- i_rst asserted asynchronously after bit 3 → all outputs return to 0 before the next clock edge, and the FSM is in IDLE.
